// File: rtl/timer_pkg.sv
// Shared definitions for the two-mode timer: state encoding, mode values,
// counting limits and TimeControl bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  localparam logic [7:0] A_MAX      = 8'd99;
  localparam logic [7:0] B_SEC_MAX  = 8'd59;
  localparam logic [7:0] B_MIN_INIT = 8'd1;
  localparam logic [7:0] B_MIN_LAST = 8'd3;
  localparam logic [6:0] B_SUB_MAX  = 7'd99;

  localparam int unsigned TCTL_CLEAR = 2;
  localparam int unsigned TCTL_RUN   = 1;
  localparam int unsigned TCTL_LAP   = 0;

  function automatic logic [7:0] init_msb(input logic mode);
    return (mode == MODE_B) ? B_MIN_INIT : 8'd0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ/TICK_HZ
// enabled cycles; holds its phase while disabled, zeroed by clear.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/two_mode_timer_counter.sv
// Time base plus stopwatch (mode A) and 3-minute elapsed-seconds count (mode B).
// Optional lap display hold is enabled with `define TIMER_LAP_EN.
module two_mode_timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ModeSel,
  input  logic [2:0] TimeControl,
  output logic [7:0] MSBBinary,
  output logic [7:0] LSBBinary,
  output logic       Running,
  output logic       Done
);

  state_e     state_q, state_d;
  logic       mode_q;
  logic [7:0] msb_q, msb_d, lsb_q, lsb_d;
  logic [6:0] sub_q, sub_d;
  logic       running_q, done_q;
  logic       tick, clr, run, mode_chg;

  assign clr      = TimeControl[TCTL_CLEAR];
  assign run      = TimeControl[TCTL_RUN];
  assign mode_chg = (ModeSel != mode_q);

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .clk   (Clock),
    .rst   (Reset),
    .enable(state_q == ST_RUN),
    .clear (state_q == ST_IDLE || state_q == ST_DONE),
    .tick  (tick)
  );

  // Ticks are consumed on any RUN edge, including the one that drops into PAUSE,
  // so the count and the prescaler phase stay in step.
  always_comb begin
    state_d = state_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    sub_d   = sub_q;
    if (clr || mode_chg) begin
      state_d = ST_IDLE;
      msb_d   = init_msb(ModeSel);
      lsb_d   = '0;
      sub_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          msb_d = init_msb(ModeSel);
          lsb_d = '0;
          sub_d = '0;
          if (run) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!run) state_d = ST_PAUSE;
          if (tick) begin
            if (mode_q == MODE_A) begin
              if (lsb_q != A_MAX) begin
                lsb_d = lsb_q + 8'd1;
              end else if (msb_q != A_MAX) begin
                lsb_d = '0;
                msb_d = msb_q + 8'd1;
              end else begin
                state_d = ST_DONE;
              end
            end else if (sub_q != B_SUB_MAX) begin
              sub_d = sub_q + 7'd1;
            end else begin
              sub_d = '0;
              if (lsb_q == B_SEC_MAX) begin
                lsb_d = '0;
                msb_d = msb_q + 8'd1;
              end else begin
                lsb_d = lsb_q + 8'd1;
              end
              if (msb_d == B_MIN_LAST && lsb_d == B_SEC_MAX) state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: if (run) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_A;
      msb_q     <= '0;
      lsb_q     <= '0;
      sub_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= ModeSel;
      msb_q     <= msb_d;
      lsb_q     <= lsb_d;
      sub_q     <= sub_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign Running = running_q;
  assign Done    = done_q;

`ifdef TIMER_LAP_EN
  logic       lap_q, lap_d, lap_prev_q;
  logic [7:0] lat_msb_q, lat_msb_d, lat_lsb_q, lat_lsb_d;

  always_comb begin
    lap_d     = lap_q;
    lat_msb_d = lat_msb_q;
    lat_lsb_d = lat_lsb_q;
    if (clr || mode_chg || state_d == ST_DONE) begin
      lap_d = 1'b0;
    end else if (state_q == ST_RUN && TimeControl[TCTL_LAP] && !lap_prev_q) begin
      lap_d = !lap_q;
      if (!lap_q) begin
        lat_msb_d = msb_q;
        lat_lsb_d = lsb_q;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lap_q      <= 1'b0;
      lap_prev_q <= 1'b0;
      lat_msb_q  <= '0;
      lat_lsb_q  <= '0;
    end else begin
      lap_q      <= lap_d;
      lap_prev_q <= TimeControl[TCTL_LAP];
      lat_msb_q  <= lat_msb_d;
      lat_lsb_q  <= lat_lsb_d;
    end
  end

  assign MSBBinary = lap_q ? lat_msb_q : msb_q;
  assign LSBBinary = lap_q ? lat_lsb_q : lsb_q;
`else
  logic unused_lap;
  assign unused_lap = TimeControl[TCTL_LAP];

  assign MSBBinary = msb_q;
  assign LSBBinary = lsb_q;
`endif

endmodule
